// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-issue stage directly upstream of the ALU.
// Decoded ops arrive from decode over valid/ready and are held in a two-entry
// skid buffer: an output register O and a skid register S. The ALU and
// writeback are driven straight from O.
// The optional writeback-to-execute forwarding is enabled by defining the
// macro ALU_ISSUE_FWD_EN. When it is undefined, the wb_* ports are ignored.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   flush                        kill all held entries (branch taken)
//   in_valid/in_ready            decode handshake; in_ready is registered
//   in_op, in_srcA, in_srcB      op and operands as read from the regfile
//   in_rsA, in_rsB, in_rd        source and destination register indices
//   wb_en, wb_rd, wb_data        writeback port, snooped for forwarding
//   out_valid/out_ready          downstream handshake on O
//   alu_op, alu_srcA, alu_srcB   ALU operands taken from O (ALU_NOP when empty)
//   out_rd                       destination register travelling with O

package alu_issue_stage_pkg;
    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } e_alu_op;
endpackage

module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned REG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  e_alu_op          in_op,
    input  logic [WIDTH-1:0] in_srcA,
    input  logic [WIDTH-1:0] in_srcB,
    input  logic [REG_W-1:0] in_rsA,
    input  logic [REG_W-1:0] in_rsB,
    input  logic [REG_W-1:0] in_rd,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output e_alu_op          alu_op,
    output logic [WIDTH-1:0] alu_srcA,
    output logic [WIDTH-1:0] alu_srcB,
    output logic [REG_W-1:0] out_rd
);

    // One held decoded op.
    typedef struct packed {
        e_alu_op          op;
        logic [WIDTH-1:0] srca;
        logic [WIDTH-1:0] srcb;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rsa;
        logic [REG_W-1:0] rsb;
    } entry_t;

    localparam entry_t EMPTY_ENTRY = '{op: ALU_NOP, default: '0};

    entry_t o_q, o_d;
    entry_t s_q, s_d;
    logic   o_valid_q, o_valid_d;
    logic   s_valid_q, s_valid_d;
    logic   in_ready_q, in_ready_d;

    entry_t in_ent;
    entry_t o_snp, s_snp, in_snp;
    logic   acc, pop;

    assign in_ent = '{op: in_op, srca: in_srcA, srcb: in_srcB,
                      rd: in_rd, rsa: in_rsA, rsb: in_rsB};

`ifdef ALU_ISSUE_FWD_EN
    // Replace any operand whose source register is being written back this cycle.
    function automatic entry_t snoop(input entry_t e, input logic en,
                                     input logic [REG_W-1:0] rd,
                                     input logic [WIDTH-1:0] data);
        entry_t r;
        r = e;
        if (en && (rd != '0)) begin
            if (e.rsa == rd) r.srca = data;
            if (e.rsb == rd) r.srcb = data;
        end
        return r;
    endfunction

    assign o_snp  = snoop(o_q, wb_en, wb_rd, wb_data);
    assign s_snp  = snoop(s_q, wb_en, wb_rd, wb_data);
    assign in_snp = snoop(in_ent, wb_en, wb_rd, wb_data);
`else
    // Forwarding disabled: operands pass through, writeback port is unused.
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_rd, wb_data};
    assign o_snp  = o_q;
    assign s_snp  = s_q;
    assign in_snp = in_ent;
`endif

    assign acc = in_valid && in_ready_q;
    assign pop = o_valid_q && out_ready;

    // Next-state: flush beats data movement; S drains into O before new input.
    always_comb begin
        o_d       = o_snp;
        s_d       = s_snp;
        o_valid_d = o_valid_q;
        s_valid_d = s_valid_q;

        if (flush) begin
            o_d       = EMPTY_ENTRY;
            s_d       = EMPTY_ENTRY;
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!o_valid_q || pop) begin
            if (s_valid_q) begin
                o_d       = s_snp;
                o_valid_d = 1'b1;
                s_d       = EMPTY_ENTRY;
                s_valid_d = 1'b0;
            end else if (acc) begin
                o_d       = in_snp;
                o_valid_d = 1'b1;
            end else begin
                // Cleared so alu_op reads ALU_NOP while O is empty.
                o_d       = EMPTY_ENTRY;
                o_valid_d = 1'b0;
            end
        end else if (acc) begin
            s_d       = in_snp;
            s_valid_d = 1'b1;
        end

        in_ready_d = !s_valid_d;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q        <= EMPTY_ENTRY;
            s_q        <= EMPTY_ENTRY;
            o_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            o_q        <= o_d;
            s_q        <= s_d;
            o_valid_q  <= o_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = o_valid_q;
    assign alu_op    = o_q.op;
    assign alu_srcA  = o_q.srca;
    assign alu_srcB  = o_q.srcb;
    assign out_rd    = o_q.rd;

endmodule
